// File: rtl/mic1_mem_pkg.sv
// Shared types for the MIC-1 memory controller: FSM states, word-op
// encoding and byte-lane selectors.
package mic1_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WORD,
        FETCH
    } state_e;

    typedef enum logic [1:0] {
        NONE,
        READ,
        WRITE
    } word_op_e;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

endpackage

// File: rtl/mic1_mem_if.sv
// Handshaked backing-memory port; the controller is the master.
interface mic1_mem_if #(
    parameter int ADDR_W = 16
) ();

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mic1_byte_lane.sv
// Picks one little-endian byte out of a 32-bit word and zero-extends it.
module mic1_byte_lane
    import mic1_mem_pkg::*;
(
    input  logic [31:0] data_word,
    input  logic [1:0]  lane_sel,
    output logic [31:0] lane_data
);

    always_comb begin
        lane_data = '0;
        case (lane_sel)
            LANE_0:  lane_data[7:0] = data_word[7:0];
            LANE_1:  lane_data[7:0] = data_word[15:8];
            LANE_2:  lane_data[7:0] = data_word[23:16];
            LANE_3:  lane_data[7:0] = data_word[31:24];
            default: lane_data = '0;
        endcase
    end

endmodule

// File: rtl/mic1_mem_ctrl.sv
// MIC-1 memory responder: serialises word read/write and byte fetch requests
// onto one backing port; the word access always goes before a paired fetch.
module mic1_mem_ctrl
    import mic1_mem_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic        fetch_req,
    input  logic [31:0] MAR,
    input  logic [31:0] MDR,
    input  logic [31:0] PC,
    output logic [31:0] RAM_data,
    output logic [31:0] ROM_data,
    output logic        rd_valid,
    output logic        fetch_valid,
    output logic        busy,
    mic1_mem_if.master  mem
);

    state_e            state, state_n;
    word_op_e          word_op, word_op_n;
    logic              fetch_pend, fetch_pend_n;
    logic [ADDR_W-1:0] mar_q, mar_n;
    logic [31:0]       mdr_q, mdr_n;
    logic [ADDR_W+1:0] pc_q, pc_n;
    logic [31:0]       ram_n, rom_n;
    logic              rd_valid_n, fetch_valid_n;
    logic [31:0]       lane_data;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{MAR[31:ADDR_W], PC[31:ADDR_W+2]};

    mic1_byte_lane u_byte_lane (
        .data_word (mem.mem_rdata),
        .lane_sel  (pc_q[1:0]),
        .lane_data (lane_data)
    );

    // busy comes straight from the state register, so requests never reach it combinationally
    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            word_op     <= NONE;
            fetch_pend  <= 1'b0;
            mar_q       <= '0;
            mdr_q       <= '0;
            pc_q        <= '0;
            RAM_data    <= '0;
            ROM_data    <= '0;
            rd_valid    <= 1'b0;
            fetch_valid <= 1'b0;
        end else begin
            state       <= state_n;
            word_op     <= word_op_n;
            fetch_pend  <= fetch_pend_n;
            mar_q       <= mar_n;
            mdr_q       <= mdr_n;
            pc_q        <= pc_n;
            RAM_data    <= ram_n;
            ROM_data    <= rom_n;
            rd_valid    <= rd_valid_n;
            fetch_valid <= fetch_valid_n;
        end
    end

    always_comb begin
        state_n       = state;
        word_op_n     = word_op;
        fetch_pend_n  = fetch_pend;
        mar_n         = mar_q;
        mdr_n         = mdr_q;
        pc_n          = pc_q;
        ram_n         = RAM_data;
        rom_n         = ROM_data;
        rd_valid_n    = 1'b0;
        fetch_valid_n = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = mar_q;
        mem.mem_wdata = mdr_q;

        case (state)
            IDLE: begin
                mar_n        = MAR[ADDR_W-1:0];
                mdr_n        = MDR;
                pc_n         = PC[ADDR_W+1:0];
                fetch_pend_n = fetch_req;
                // a simultaneous read and write collapses to the write
                if (wr_req) begin
                    word_op_n = WRITE;
                end else if (rd_req) begin
                    word_op_n = READ;
                end else begin
                    word_op_n = NONE;
                end
                if (wr_req || rd_req) begin
                    state_n = WORD;
                end else if (fetch_req) begin
                    state_n = FETCH;
                end
            end
            WORD: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = (word_op == WRITE);
                if (mem.mem_ack) begin
                    if (word_op == READ) begin
                        ram_n      = mem.mem_rdata;
                        rd_valid_n = 1'b1;
                    end
                    word_op_n = NONE;
                    state_n   = fetch_pend ? FETCH : IDLE;
                end
            end
            FETCH: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = pc_q[ADDR_W+1:2];
                if (mem.mem_ack) begin
                    rom_n         = lane_data;
                    fetch_valid_n = 1'b1;
                    fetch_pend_n  = 1'b0;
                    state_n       = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// Directed bench for mic1_mem_ctrl: a table of single transactions against a
// wait-state memory model, plus busy-ignore and reset-abandon sequences.
module tb_mic1_mem_ctrl;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        fetch;
        logic [31:0] mar;
        logic [31:0] mdr;
        logic [31:0] pc;
        int          ws;
        int          exp_rd_cycle;
        int          exp_fetch_cycle;
        logic [31:0] exp_ram;
        logic [31:0] exp_rom;
        int          exp_busy;
        int          exp_req;
        int          exp_we;
    } vec_t;

    typedef struct {
        int          rd_cycle;
        int          fetch_cycle;
        int          busy_cnt;
        int          req_cnt;
        int          we_cnt;
        int          overlap;
        logic [31:0] ram;
        logic [31:0] rom;
    } meas_t;

    logic        clock;
    logic        reset_n;
    logic        rd_req, wr_req, fetch_req;
    logic [31:0] MAR, MDR, PC;
    logic [31:0] RAM_data, ROM_data;
    logic        rd_valid, fetch_valid, busy;

    logic        force_ack;
    int          wait_states;
    int          wcnt;
    logic [31:0] tb_mem [0:255];

    int check_count;
    int error_count;

    vec_t  vecs [12];
    meas_t m;

    mic1_mem_if #(.ADDR_W(16)) mem_bus ();

    mic1_mem_ctrl #(.ADDR_W(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .fetch_req   (fetch_req),
        .MAR         (MAR),
        .MDR         (MDR),
        .PC          (PC),
        .RAM_data    (RAM_data),
        .ROM_data    (ROM_data),
        .rd_valid    (rd_valid),
        .fetch_valid (fetch_valid),
        .busy        (busy),
        .mem         (mem_bus.master)
    );

    always #5 clock = ~clock;

    // Memory model: acks after wait_states stalled cycles, forced ack emulates a late reply
    assign mem_bus.mem_ack   = force_ack | (mem_bus.mem_req && (wcnt == wait_states));
    assign mem_bus.mem_rdata = tb_mem[mem_bus.mem_addr[7:0]];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wcnt         <= 0;
            tb_mem[8'h01] <= 32'hA1B2C3D4;
            tb_mem[8'h02] <= 32'h11223344;
            tb_mem[8'h10] <= 32'hDEADBEEF;
            tb_mem[8'h20] <= 32'h0;
            tb_mem[8'h21] <= 32'h0;
            tb_mem[8'h30] <= 32'hCAFEF00D;
        end else if (mem_bus.mem_req) begin
            if (mem_bus.mem_ack) begin
                if (mem_bus.mem_we) tb_mem[mem_bus.mem_addr[7:0]] <= mem_bus.mem_wdata;
                wcnt <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issue one request at an edge, scramble the datapath inputs, then observe 15 cycles
    task automatic applyStimulus(input vec_t v, output meas_t r);
        r = '{default: 0};
        @(negedge clock);
        wait_states = v.ws;
        rd_req    = v.rd;
        wr_req    = v.wr;
        fetch_req = v.fetch;
        MAR = v.mar;
        MDR = v.mdr;
        PC  = v.pc;
        @(posedge clock);
        #1;
        rd_req = 1'b0; wr_req = 1'b0; fetch_req = 1'b0;
        MAR = 32'hFFFF_FFFF; MDR = 32'hFFFF_FFFF; PC = 32'hFFFF_FFFF;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clock);
            if (rd_valid && r.rd_cycle == 0) r.rd_cycle = c;
            if (fetch_valid && r.fetch_cycle == 0) r.fetch_cycle = c;
            if (rd_valid && fetch_valid) r.overlap++;
            if (busy) r.busy_cnt++;
            if (mem_bus.mem_req) r.req_cnt++;
            if (mem_bus.mem_we && mem_bus.mem_wdata == v.mdr) r.we_cnt++;
        end
        r.ram = RAM_data;
        r.rom = ROM_data;
    endtask

    initial begin
        int req_cnt, rd_pulses, fetch_pulses;
        clock = 1'b0; reset_n = 1'b0; force_ack = 1'b0; wait_states = 0;
        rd_req = 1'b0; wr_req = 1'b0; fetch_req = 1'b0;
        MAR = '0; MDR = '0; PC = '0;
        check_count = 0; error_count = 0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0,        32'h0,  0, 2, 0, 32'hDEADBEEF, 32'h00, 1, 1, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678, 32'h0,  3, 0, 0, 32'hDEADBEEF, 32'h00, 4, 4, 4};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h0,  32'h0,        32'h4,  0, 0, 2, 32'hDEADBEEF, 32'hD4, 1, 1, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0,  32'h0,        32'h5,  0, 0, 2, 32'hDEADBEEF, 32'hC3, 1, 1, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0,  32'h0,        32'h6,  0, 0, 2, 32'hDEADBEEF, 32'hB2, 1, 1, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h0,  32'h0,        32'h7,  0, 0, 2, 32'hDEADBEEF, 32'hA1, 1, 1, 0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h30, 32'h0,        32'h8,  0, 2, 3, 32'hCAFEF00D, 32'h44, 2, 2, 0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h21, 32'h55AA55AA, 32'h0,  0, 0, 0, 32'hCAFEF00D, 32'h44, 1, 1, 1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h20, 32'h0,        32'h0,  1, 3, 0, 32'h12345678, 32'h44, 2, 2, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h21, 32'h0,        32'h0,  0, 2, 0, 32'h55AA55AA, 32'h44, 1, 1, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'h0,        32'hB,  2, 0, 4, 32'h55AA55AA, 32'h11, 3, 3, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'h0,        32'h6,  1, 3, 5, 32'hDEADBEEF, 32'hB2, 4, 4, 0};

        #2;
        checkOutput("reset RAM_data", RAM_data, 32'h0);
        checkOutput("reset ROM_data", ROM_data, 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset mem_req", 32'(mem_bus.mem_req), 32'h0);
        checkOutput("reset rd_valid", 32'(rd_valid), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], m);
            checkOutput($sformatf("v%0d rd_valid cycle", i), 32'(m.rd_cycle), 32'(vecs[i].exp_rd_cycle));
            checkOutput($sformatf("v%0d fetch_valid cycle", i), 32'(m.fetch_cycle), 32'(vecs[i].exp_fetch_cycle));
            checkOutput($sformatf("v%0d RAM_data", i), m.ram, vecs[i].exp_ram);
            checkOutput($sformatf("v%0d ROM_data", i), m.rom, vecs[i].exp_rom);
            checkOutput($sformatf("v%0d busy cycles", i), 32'(m.busy_cnt), 32'(vecs[i].exp_busy));
            checkOutput($sformatf("v%0d mem_req cycles", i), 32'(m.req_cnt), 32'(vecs[i].exp_req));
            checkOutput($sformatf("v%0d mem_we cycles", i), 32'(m.we_cnt), 32'(vecs[i].exp_we));
            checkOutput($sformatf("v%0d valid overlap", i), 32'(m.overlap), 32'h0);
        end

        // Requests held while busy must not start a second access
        @(negedge clock);
        wait_states = 3;
        rd_req = 1'b1; MAR = 32'h21;
        @(posedge clock);
        #1;
        rd_req = 1'b1; fetch_req = 1'b1; MAR = 32'h30; PC = 32'h4;
        req_cnt = 0; rd_pulses = 0; fetch_pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 4) begin
                rd_req = 1'b0; fetch_req = 1'b0;
            end
            if (mem_bus.mem_req) req_cnt++;
            if (rd_valid) rd_pulses++;
            if (fetch_valid) fetch_pulses++;
        end
        checkOutput("busy-ignore mem_req cycles", 32'(req_cnt), 32'd4);
        checkOutput("busy-ignore rd_valid pulses", 32'(rd_pulses), 32'd1);
        checkOutput("busy-ignore fetch_valid pulses", 32'(fetch_pulses), 32'd0);
        checkOutput("busy-ignore RAM_data", RAM_data, 32'h55AA55AA);
        checkOutput("busy-ignore ROM_data", ROM_data, 32'hB2);

        // Reset in the middle of a stalled read, then a late ack in IDLE
        @(negedge clock);
        wait_states = 5;
        rd_req = 1'b1; MAR = 32'h30;
        @(posedge clock);
        #1;
        rd_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("mid-op busy before reset", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("mid-op reset mem_req", 32'(mem_bus.mem_req), 32'h0);
        checkOutput("mid-op reset busy", 32'(busy), 32'h0);
        checkOutput("mid-op reset RAM_data", RAM_data, 32'h0);
        checkOutput("mid-op reset ROM_data", ROM_data, 32'h0);
        checkOutput("mid-op reset mem_we", 32'(mem_bus.mem_we), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        force_ack = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            checkOutput($sformatf("late ack c%0d RAM_data", c), RAM_data, 32'h0);
            checkOutput($sformatf("late ack c%0d ROM_data", c), ROM_data, 32'h0);
            checkOutput($sformatf("late ack c%0d rd_valid", c), 32'(rd_valid), 32'h0);
            checkOutput($sformatf("late ack c%0d fetch_valid", c), 32'(fetch_valid), 32'h0);
            checkOutput($sformatf("late ack c%0d busy", c), 32'(busy), 32'h0);
        end
        force_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/mic1_mem_ctrl.md
# mic1_mem_ctrl

Memory-side responder for the MIC-1 datapath. It accepts the datapath's word read/write requests (MAR/MDR) and byte opcode fetches (PC), serialises them onto a single handshaked backing-memory port, and returns read words on `RAM_data` and fetched bytes on `ROM_data`. Minimum turnaround matches MIC-1 semantics: data issued at edge n is usable in cycle n+2. `busy` stalls the microsequencer while the port is occupied.

## Interface
- `ADDR_W`, 16: backing-memory word-address width.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rd_req` in 1: word read request (MIR read bit).
- `wr_req` in 1: word write request (MIR write bit).
- `fetch_req` in 1: byte fetch request (MIR fetch bit).
- `MAR` in 32: word address; `MAR[ADDR_W-1:0]` is used.
- `MDR` in 32: write data.
- `PC` in 32: byte address. Word is `PC[ADDR_W+1:2]`, lane is `PC[1:0]`.
- `RAM_data` out 32: last word read, held until the next read completes.
- `ROM_data` out 32: last fetched byte, zero-extended in `[7:0]`, held.
- `rd_valid` out 1: one-cycle pulse when `RAM_data` updates.
- `fetch_valid` out 1: one-cycle pulse when `ROM_data` updates.
- `busy` out 1: controller cannot accept requests.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out 32: backing-port request.
- `mem_ack` in 1, `mem_rdata` in 32: backing-port completion and read data.

## Operation
- **FSM states:** IDLE, WORD, FETCH.
- **Accept:** at any rising edge with `busy`=0, the controller captures:
  - word op: `wr_req` → write; else `rd_req` → read.
  - `fetch_req` into a pending-fetch flag.
  - `MAR`, `MDR`, `PC` into holding registers.
  - The datapath may change `MAR`, `MDR` and `PC` after the accept edge.
- **Conflicts and ignored requests:**
  - `rd_req` and `wr_req` together: the write is performed and the read is dropped.
  - Requests while `busy`=1 are ignored. The datapath must honour `busy`.
- **Transitions:**
  - IDLE → WORD if a word op was captured; else IDLE → FETCH if a fetch was captured.
  - WORD → FETCH on `mem_ack` if a fetch is pending; else WORD → IDLE.
  - FETCH → IDLE on `mem_ack`.
- **Backing-port drive:**
  - `mem_req`=1 in WORD and FETCH.
  - `mem_we`=1 only in WORD for a write.
  - `mem_addr` is the held MAR in WORD and the held PC word in FETCH.
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are stable until the edge where `mem_ack` is sampled.
  - `mem_wdata` = held MDR.
- **Completion:**
  - Read: `RAM_data` is loaded with `mem_rdata` on the ack edge.
  - Fetch: `ROM_data` is loaded on the ack edge. Lane 0 = `mem_rdata[7:0]` … lane 3 = `[31:24]` (little-endian).
  - A write produces no valid pulse.
- **`busy`:** equals state≠IDLE. It is registered, with no combinational path from request inputs.
- **Reset values:**
  - `reset_n` low clears the FSM to IDLE, the pending flag, the holding registers, `RAM_data`, `ROM_data`, `rd_valid`, `fetch_valid`, `mem_req` and `mem_we` to 0, immediately.
  - An in-flight access is abandoned, and a late `mem_ack` after reset is ignored.
- **Stray ack:** `mem_ack` in IDLE is ignored.

## Timing
- **Zero-wait read or fetch** (`mem_ack` high in the first `mem_req` cycle):
  - request sampled at edge n;
  - `mem_req` and `busy` high in cycle n+1;
  - data and valid pulse in cycle n+2, with `busy` low.
- **Wait states:** each extra cycle `mem_ack` stays low adds one cycle.
- **Read+fetch in the same cycle:** word access first.
  - `RAM_data` valid in n+2, FETCH in n+2, `ROM_data` valid in n+3.
  - `busy` is high in n+1 and n+2.
- `rd_valid` and `fetch_valid` are never high in the same cycle.
- Back-to-back accept is possible in the first cycle `busy` is low.

## Structure
- **Package `mic1_mem_pkg`:** FSM state enum (IDLE, WORD, FETCH), word-op encoding (NONE, READ, WRITE), lane-select constants.
- **Sub-module `mic1_byte_lane`:** combinational; lane select plus zero-extend from a 32-bit word and a 2-bit lane to 32 bits.
- Everything else lives in a single always_ff/always_comb pair in `mic1_mem_ctrl`.

## Test plan
- Read, zero-wait: `MAR`=0x0010 with mem[0x10]=0xDEADBEEF, `rd_req` at edge 0 → `mem_req` in cycle 1, `RAM_data`=0xDEADBEEF with `rd_valid` pulse in cycle 2, `busy` high in cycle 1 only.
- Write with 3 wait states: `MAR`=0x20, `MDR`=0x12345678, `wr_req` → `mem_we`=1 and `mem_wdata`=0x12345678 stable for 4 cycles; mem[0x20] updated; no valid pulse.
- Fetch all four lanes: mem[1]=0xA1B2C3D4, `PC`=4..7 → `ROM_data` = 0xD4, 0xC3, 0xB2, 0xA1, each zero-extended, each in cycle n+2.
- Read and fetch in the same cycle, with `MAR`/`PC` changed after accept → captured addresses used; `rd_valid` in n+2, `fetch_valid` in n+3.
- Conflicts and ignored requests:
  - `rd_req` and `wr_req` together → a write only, no `rd_valid`.
  - A request while `busy` → ignored, no extra `mem_req`.
- Reset mid-op: `reset_n` low during WORD with `mem_ack` low → `mem_req`, `busy`, `RAM_data` and `ROM_data` at 0 immediately. After release, a late `mem_ack` leaves all outputs at 0.
